// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, 33-cycle latency.
// Optional MULDIV_FAST_MUL_EN: single-cycle '*' multiply (division stays iterative).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               isDiv_q, isDiv_d;
    logic               negRes_q, negRes_d;
    logic               negRem_q, negRem_d;
    logic [WIDTH-1:0]   bAbs_q, bAbs_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               isDiv, aNeg, bNeg;
    logic [WIDTH-1:0]   aAbs, bAbs;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic               divGe;
    logic [2*WIDTH-1:0] mulStep, divStep, prodFix;
    logic [WIDTH-1:0]   quoFix, remFix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;
`endif

    assign isDiv = op[1];
    assign aNeg  = ~op[0] & a[WIDTH-1];
    assign bNeg  = ~op[0] & b[WIDTH-1];
    assign aAbs  = aNeg ? (~a + 1'b1) : a;
    assign bAbs  = bNeg ? (~b + 1'b1) : b;

`ifdef MULDIV_FAST_MUL_EN
    assign fastProd = {{WIDTH{1'b0}}, aAbs} * {{WIDTH{1'b0}}, bAbs};
`endif

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bAbs_q} : '0);
    assign mulStep  = {mulSum, acc_q[WIDTH-1:1]};
    assign divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, bAbs_q};
    assign divGe    = divShift >= {1'b0, bAbs_q};
    assign divStep  = divGe ? {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    // A zero divisor leaves remainder = |a|, so restoring the dividend sign yields raw a
    assign prodFix = negRes_q ? (~acc_q + 1'b1) : acc_q;
    assign quoFix  = negRes_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign remFix  = negRem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        isDiv_d  = isDiv_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        bAbs_d   = bAbs_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    isDiv_d  = isDiv;
                    bAbs_d   = bAbs;
                    negRes_d = (aNeg ^ bNeg) & ~(isDiv & (b == '0));
                    negRem_d = isDiv & aNeg;
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, aAbs};
                    state_d  = S_RUN;
`ifdef MULDIV_FAST_MUL_EN
                    if (!isDiv) begin
                        acc_d   = fastProd;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = isDiv_q ? divStep : mulStep;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (isDiv_q) begin
                    lo_d = quoFix;
                    hi_d = remFix;
                end else begin
                    {hi_d, lo_d} = prodFix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            bAbs_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            isDiv_q  <= isDiv_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            bAbs_q   <= bAbs_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule
